// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the Mini SRC datapath.
// Ports: clock/clear (async active-low), ir/ConFFQ in, datapath strobes, ALU selects and run out.
module control_sequencer #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        ConFFQ,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDMuxread,
  output logic        RAMread,
  output logic        RAMwrite,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        CSEout,
  output logic        CONin,
  output logic        InPortout,
  output logic        OutPortin,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        MUL,
  output logic        DIV,
  output logic        NEG,
  output logic        NOT,
  output logic        run
);

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  state_t state;
  state_t state_n;

  logic [4:0] opc;
  logic       ir_unused;
  logic       is_ld;
  logic       is_ldi;
  logic       is_st;
  logic       is_rtype;
  logic       is_imm;
  logic       is_md;
  logic       is_un;
  logic       is_br;
  logic       is_jr;
  logic       is_jal;
  logic       is_in;
  logic       is_out;
  logic       is_mfhi;
  logic       is_mflo;
  logic       is_illegal;
  logic       is_halt;
  logic [2:0] last;

  assign opc       = ir[31:27];
  assign ir_unused = ^ir[26:0];

  assign is_ld      = opc == 5'd0;
  assign is_ldi     = opc == 5'd1;
  assign is_st      = opc == 5'd2;
  assign is_rtype   = (opc >= 5'd3) && (opc <= 5'd11);
  assign is_imm     = (opc >= 5'd12) && (opc <= 5'd14);
  assign is_md      = (opc == 5'd15) || (opc == 5'd16);
  assign is_un      = (opc == 5'd17) || (opc == 5'd18);
  assign is_br      = opc == 5'd19;
  assign is_jr      = opc == 5'd20;
  assign is_jal     = opc == 5'd21;
  assign is_in      = opc == 5'd22;
  assign is_out     = opc == 5'd23;
  assign is_mfhi    = opc == 5'd24;
  assign is_mflo    = opc == 5'd25;
  assign is_illegal = opc[4:2] == 3'b111;
  assign is_halt    = (opc == 5'd27)
                   || (is_illegal && HALT_ON_ILLEGAL);

  // Final T-step of the execute phase for the decoded opcode.
  always_comb begin
    last = 3'd3;
    if (is_ld || is_st)
      last = 3'd7;
    else if (is_md || is_br)
      last = 3'd6;
    else if (is_rtype || is_imm || is_ldi)
      last = 3'd5;
    else if (is_un || is_jal)
      last = 3'd4;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)
      state <= RST;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RST:  state_n = T0;
      T0:   state_n = T1;
      T1:   state_n = T2;
      T2:   state_n = T3;
      T3: begin
        if (is_halt)
          state_n = HALT;
        else if (last == 3'd3)
          state_n = T0;
        else
          state_n = T4;
      end
      T4:   state_n = (last == 3'd4) ? T0 : T5;
      T5:   state_n = (last == 3'd5) ? T0 : T6;
      T6:   state_n = (last == 3'd6) ? T0 : T7;
      T7:   state_n = T0;
      HALT: state_n = HALT;
      default: state_n = RST;
    endcase
  end

  assign run = (state != RST) && (state != HALT);

  always_comb begin
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    MDMuxread = 1'b0;
    RAMread   = 1'b0;
    RAMwrite  = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    HIout     = 1'b0;
    LOin      = 1'b0;
    LOout     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    CSEout    = 1'b0;
    CONin     = 1'b0;
    InPortout = 1'b0;
    OutPortin = 1'b0;
    ADD       = 1'b0;
    SUB       = 1'b0;
    AND       = 1'b0;
    OR        = 1'b0;
    SHR       = 1'b0;
    SHRA      = 1'b0;
    SHL       = 1'b0;
    ROR       = 1'b0;
    ROL       = 1'b0;
    MUL       = 1'b0;
    DIV       = 1'b0;
    NEG       = 1'b0;
    NOT       = 1'b0;
    unique case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        Zlowout   = 1'b1;
        PCin      = 1'b1;
        MDMuxread = 1'b1;
        RAMread   = 1'b1;
        MDRin     = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        unique case (1'b1)
          is_rtype | is_imm: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          is_ld | is_ldi | is_st: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end
          is_md: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          is_un: begin
            Grb    = 1'b1;
            Rout   = 1'b1;
            Zlowin = 1'b1;
            NEG    = opc == 5'd17;
            NOT    = opc == 5'd18;
          end
          is_br: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            CONin = 1'b1;
          end
          is_jr: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            PCin = 1'b1;
          end
          is_jal: begin
            PCout = 1'b1;
            Grb   = 1'b1;
            Rin   = 1'b1;
          end
          is_in: begin
            InPortout = 1'b1;
            Gra       = 1'b1;
            Rin       = 1'b1;
          end
          is_out: begin
            Gra       = 1'b1;
            Rout      = 1'b1;
            OutPortin = 1'b1;
          end
          is_mfhi: begin
            HIout = 1'b1;
            Gra   = 1'b1;
            Rin   = 1'b1;
          end
          is_mflo: begin
            LOout = 1'b1;
            Gra   = 1'b1;
            Rin   = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        unique case (1'b1)
          is_rtype: begin
            Grc    = 1'b1;
            Rout   = 1'b1;
            Zlowin = 1'b1;
            ADD    = opc == 5'd3;
            SUB    = opc == 5'd4;
            AND    = opc == 5'd5;
            OR     = opc == 5'd6;
            ROR    = opc == 5'd7;
            ROL    = opc == 5'd8;
            SHR    = opc == 5'd9;
            SHRA   = opc == 5'd10;
            SHL    = opc == 5'd11;
          end
          is_imm: begin
            CSEout = 1'b1;
            Zlowin = 1'b1;
            ADD    = opc == 5'd12;
            AND    = opc == 5'd13;
            OR     = opc == 5'd14;
          end
          is_ld | is_ldi | is_st: begin
            CSEout = 1'b1;
            ADD    = 1'b1;
            Zlowin = 1'b1;
          end
          is_md: begin
            Grb     = 1'b1;
            Rout    = 1'b1;
            Zlowin  = 1'b1;
            Zhighin = 1'b1;
            DIV     = opc == 5'd15;
            MUL     = opc == 5'd16;
          end
          is_un: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          is_br: begin
            PCout = 1'b1;
            Yin   = 1'b1;
          end
          is_jal: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            PCin = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        unique case (1'b1)
          is_rtype | is_imm | is_ldi: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          is_ld | is_st: begin
            Zlowout = 1'b1;
            MARin   = 1'b1;
          end
          is_md: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          is_br: begin
            CSEout = 1'b1;
            ADD    = 1'b1;
            Zlowin = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        unique case (1'b1)
          is_ld: begin
            MDMuxread = 1'b1;
            RAMread   = 1'b1;
            MDRin     = 1'b1;
          end
          // MDMuxread stays low so MDR latches the bus.
          is_st: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            MDRin = 1'b1;
          end
          is_md: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
          end
          is_br: begin
            Zlowout = 1'b1;
            PCin    = ConFFQ;
          end
          default: ;
        endcase
      end
      T7: begin
        unique case (1'b1)
          is_ld: begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end
          is_st: RAMwrite = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore-style control unit for the Mini SRC datapath.
- Generates every datapath strobe for instruction fetch and execute, one T-step per clock, and loops back to fetch after each instruction.
- Replaces the bench-driven strobe sequences; it connects directly to the datapath control inputs and reads ir and ConFFQ back from it.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = undefined opcode enters HALT; 0 = treated as nop

Ports:
clock  in  1  system clock; the datapath samples strobes on the rising edge
clear  in  1  asynchronous, active-low reset (asserted = 0)
ir  in  32  datapath IR contents; opcode = ir[31:27]
ConFFQ  in  1  branch-condition flip-flop from the datapath
PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite, IRin, Yin  out  1 each  datapath strobes
Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout  out  1 each  datapath strobes
Gra, Grb, Grc, Rin, Rout, BAout, CSEout, CONin, InPortout, OutPortin  out  1 each  datapath strobes
ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT  out  1 each  ALU op selects
run  out  1  1 in every state except RST and HALT

Behaviour:
- States: RST, T0..T7, HALT; 4-bit state register.
- Outputs are decoded combinationally from the state and the opcode only.
  - No strobe is active in RST or HALT, or in any step not listed below.
- clear = 0 forces RST asynchronously, from any state and mid-instruction; all outputs are 0 and run = 0.
- First rising edge after clear goes to 1: RST -> T0.
- Fetch, common to all opcodes:
  - T0: PCout MARin IncPC Zlowin
  - T1: Zlowout PCin MDMuxread RAMread MDRin
  - T2: MDRout IRin
- Decode happens in T3. ir is stable from T3 onward because IRin pulses only in T2.
- Execute sequences. The last listed step of each sequence returns to T0 on the next edge.
  - add/sub/and/or/ror/rol/shr/shra/shl (00011-01011):
    - T3: Grb Rout Yin
    - T4: Grc Rout <op> Zlowin
    - T5: Zlowout Gra Rin
  - addi/andi/ori (01100-01110):
    - T3: Grb Rout Yin
    - T4: CSEout <ADD|AND|OR> Zlowin
    - T5: Zlowout Gra Rin
  - div (01111) / mul (10000):
    - T3: Gra Rout Yin
    - T4: Grb Rout <op> Zlowin Zhighin
    - T5: Zlowout LOin
    - T6: Zhighout HIin
  - neg (10001) / not (10010):
    - T3: Grb Rout <op> Zlowin
    - T4: Zlowout Gra Rin
  - ld (00000):
    - T3: Grb BAout Yin
    - T4: CSEout ADD Zlowin
    - T5: Zlowout MARin
    - T6: MDMuxread RAMread MDRin
    - T7: MDRout Gra Rin
  - ldi (00001):
    - T3: Grb BAout Yin
    - T4: CSEout ADD Zlowin
    - T5: Zlowout Gra Rin
  - st (00010):
    - T3-T5: as ld
    - T6: Gra Rout MDRin, with MDMuxread = 0
    - T7: RAMwrite
  - br (10011):
    - T3: Gra Rout CONin
    - T4: PCout Yin
    - T5: CSEout ADD Zlowin
    - T6: Zlowout, plus PCin only if ConFFQ = 1 in T6
  - jr (10100): T3: Gra Rout PCin
  - jal (10101):
    - T3: PCout Grb Rin (ir[22:19] = r15 by encoding)
    - T4: Gra Rout PCin
  - in (10110): T3: InPortout Gra Rin
  - out (10111): T3: Gra Rout OutPortin
  - mfhi (11000): T3: HIout Gra Rin
  - mflo (11001): T3: LOout Gra Rin
  - nop (11010): T3: no strobes
  - halt (11011): T3 -> HALT; HALT is held until clear.
  - Opcodes 11100-11111: behave as nop, or as halt when HALT_ON_ILLEGAL = 1.
- Exactly one ALU op select may be high in any state; the bench asserts this.
- Cycles per instruction: 4 for 1-step ops (jr/in/out/mfhi/mflo/nop); 5 for neg/not/jal; 6 for R-type, immediate and ldi; 7 for mul/div/br; 8 for ld/st.

Test Plan:
- clear pulsed low for 15 ns mid-T4 of an add -> all outputs 0 immediately, run = 0; one cycle later T0 shows PCout = MARin = IncPC = Zlowin = 1.
- ir = 0xB2000000 (in R4) -> T3 asserts InPortout Gra Rin; with InPortdata = 0x12345678, R4 = 0x12345678 and the next cycle is T0.
- ir = 0xBA000000 (out R4) -> T3 asserts Gra Rout OutPortin; OutPortdata = 0x12345678.
- ld R1, 0x55(R2): ir = 0x00900055, RAM[0x55] = 0x8B -> 8-cycle sequence exactly as specified; R1 = 0x8B.
- br with ConFFQ = 1, then a repeat with ConFFQ = 0 -> PCin asserted in T6 only in the first case; Zlowout asserted in T6 in both.
- Opcode 11011 (halt) -> HALT after T3; run = 0 with no strobes for 20 cycles; clear low then high -> fetch restarts.
